regfile_param: RTL and testbench

Parametrised register file for the tinyrv core, replacing the fixed 8×16 register file. Provides two read ports, one write port, optional same-cycle write bypass, optional registered read outputs for a pipelined datapath, a hardwired zero register, a sequential clear sweep and a debug read port. Sits between instruction decode (`src1`/`src2`/`tgt` fields) and the ALU/data-memory datapath.

---
 rtl/regfile_param_if.sv | 33 +++
 rtl/regfile_param.sv | 125 ++++++++++++
 tb/tb_regfile_param.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param_if
// Brief    : Register-file access bundle (read/write/debug ports, sweep ctrl)
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [DATA_W-1:0] src1_dat;
    logic [DATA_W-1:0] src2_dat;
    logic [ADDR_W-1:0] tgt;
    logic [DATA_W-1:0] tgt_dat;
    logic              we;
    logic              clr;
    logic              busy;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_dat;

    modport master (
        output src1, src2, tgt, tgt_dat, we, clr, dbg_addr,
        input  src1_dat, src2_dat, busy, dbg_dat
    );

    modport slave (
        input  src1, src2, tgt, tgt_dat, we, clr, dbg_addr,
        output src1_dat, src2_dat, busy, dbg_dat
    );
endinterface
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param
// Brief    : Parametrised 2R/1W register file with bypass, zero reg, clear sweep
// Revision : 1.0 - initial release
// ============================================================================
module regfile_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    regfile_param_if.slave bus
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NREGS - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_sweep_wr;
    logic              w_busy;
    logic              w_we_eff;
    logic [DATA_W-1:0] r_mem [NREGS];
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdat [2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep_wr  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.clr) begin
                    w_state_nxt = S_SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            S_SWEEP: begin
                w_busy     = 1'b1;
                w_sweep_wr = 1'b1;
                w_cnt_nxt  = r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Writes are only honoured in IDLE; the zero register silently drops them.
    assign w_we_eff = bus.we && (r_state == S_IDLE) &&
                      !((ZERO_REG != 0) && (bus.tgt == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_sweep_wr) begin
            r_mem[r_cnt] <= '0;
        end else if (w_we_eff) begin
            r_mem[bus.tgt] <= bus.tgt_dat;
        end
    end

    assign w_raddr[0] = bus.src1;
    assign w_raddr[1] = bus.src2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdat[p] = r_mem[w_raddr[p]];
            if ((BYPASS != 0) && w_we_eff && (bus.tgt == w_raddr[p])) begin
                w_rdat[p] = bus.tgt_dat;
            end
            if ((ZERO_REG != 0) && (w_raddr[p] == '0)) begin
                w_rdat[p] = '0;
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] r_rdat [2];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rdat[0] <= '0;
                    r_rdat[1] <= '0;
                end else begin
                    r_rdat[0] <= w_rdat[0];
                    r_rdat[1] <= w_rdat[1];
                end
            end
            assign bus.src1_dat = r_rdat[0];
            assign bus.src2_dat = r_rdat[1];
        end else begin : g_rd_comb
            assign bus.src1_dat = w_rdat[0];
            assign bus.src2_dat = w_rdat[1];
        end
    endgenerate

    assign bus.dbg_dat = ((ZERO_REG != 0) && (bus.dbg_addr == '0)) ? '0 : r_mem[bus.dbg_addr];
    assign bus.busy    = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_param
// Brief    : Four-configuration randomized bench against a behavioural model
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_param;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  src1, src2, tgt, dbg_addr;
    logic [15:0] tgt_dat;
    logic        we, clr;

    regfile_param_if #(.DATA_W(16), .ADDR_W(3)) ifa ();
    regfile_param_if #(.DATA_W(16), .ADDR_W(3)) ifb ();
    regfile_param_if #(.DATA_W(16), .ADDR_W(3)) ifc ();
    regfile_param_if #(.DATA_W(8),  .ADDR_W(2)) ifd ();

    assign ifa.src1 = src1;  assign ifa.src2 = src2;  assign ifa.tgt = tgt;  assign ifa.tgt_dat = tgt_dat;
    assign ifa.we = we;      assign ifa.clr = clr;    assign ifa.dbg_addr = dbg_addr;
    assign ifb.src1 = src1;  assign ifb.src2 = src2;  assign ifb.tgt = tgt;  assign ifb.tgt_dat = tgt_dat;
    assign ifb.we = we;      assign ifb.clr = clr;    assign ifb.dbg_addr = dbg_addr;
    assign ifc.src1 = src1;  assign ifc.src2 = src2;  assign ifc.tgt = tgt;  assign ifc.tgt_dat = tgt_dat;
    assign ifc.we = we;      assign ifc.clr = clr;    assign ifc.dbg_addr = dbg_addr;
    assign ifd.src1 = src1[1:0]; assign ifd.src2 = src2[1:0]; assign ifd.tgt = tgt[1:0];
    assign ifd.tgt_dat = tgt_dat[7:0]; assign ifd.we = we; assign ifd.clr = clr;
    assign ifd.dbg_addr = dbg_addr[1:0];

    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1), .READ_REG(0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0), .READ_REG(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1), .READ_REG(1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
    regfile_param #(.DATA_W(8),  .ADDR_W(2), .ZERO_REG(0), .BYPASS(1), .READ_REG(0))
        dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd.slave));

    // Configuration of each instance as seen by the reference model
    int          c_zero [4] = '{1, 1, 1, 0};
    int          c_byp  [4] = '{1, 0, 1, 1};
    int          c_rr   [4] = '{0, 0, 1, 0};
    int          c_n    [4] = '{8, 8, 8, 4};
    logic [15:0] c_mask [4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h00FF};

    logic [15:0] m_mem [4][8];
    logic [15:0] m_rr  [4][2];
    int          m_start [4];
    int          cyc;
    bit          checking;
    int          n_chk;
    int          n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Sweep occupies cycles [start, start+N) of the model's cycle count
    function automatic bit m_busy(input int i);
        return (cyc >= m_start[i]) && (cyc < m_start[i] + c_n[i]);
    endfunction

    function automatic bit m_eff(input int i);
        return we && !m_busy(i) && !((c_zero[i] != 0) && ((int'(tgt) % c_n[i]) == 0));
    endfunction

    function automatic logic [15:0] m_read(input int i, input logic [2:0] addr, input bit dbg);
        int a = int'(addr) % c_n[i];
        int w = int'(tgt) % c_n[i];
        if ((c_zero[i] != 0) && (a == 0)) return 16'h0000;
        if (!dbg && (c_byp[i] != 0) && m_eff(i) && (w == a)) return tgt_dat & c_mask[i];
        return m_mem[i][a];
    endfunction

    task automatic get_obs(input int i, output logic [15:0] s1, output logic [15:0] s2,
                           output logic [15:0] dg, output logic bsy);
        case (i)
            0:       begin s1 = ifa.src1_dat; s2 = ifa.src2_dat; dg = ifa.dbg_dat; bsy = ifa.busy; end
            1:       begin s1 = ifb.src1_dat; s2 = ifb.src2_dat; dg = ifb.dbg_dat; bsy = ifb.busy; end
            2:       begin s1 = ifc.src1_dat; s2 = ifc.src2_dat; dg = ifc.dbg_dat; bsy = ifc.busy; end
            default: begin
                s1 = {8'h00, ifd.src1_dat}; s2 = {8'h00, ifd.src2_dat};
                dg = {8'h00, ifd.dbg_dat};  bsy = ifd.busy;
            end
        endcase
    endtask

    // One clock: compare all instances mid-cycle, then advance the model past the edge
    task automatic cycle();
        logic [15:0] s1, s2, dg, e1, e2;
        logic        bsy;
        logic [15:0] nr [4][2];
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            e1 = m_read(i, src1, 1'b0);
            e2 = m_read(i, src2, 1'b0);
            nr[i][0] = e1;
            nr[i][1] = e2;
            if (checking) begin
                get_obs(i, s1, s2, dg, bsy);
                chk($sformatf("dut%0d busy", i), {31'd0, bsy}, {31'd0, m_busy(i)});
                chk($sformatf("dut%0d dbg_dat", i), {16'd0, dg}, {16'd0, m_read(i, dbg_addr, 1'b1)});
                chk($sformatf("dut%0d src1_dat", i), {16'd0, s1}, {16'd0, (c_rr[i] != 0) ? m_rr[i][0] : e1});
                chk($sformatf("dut%0d src2_dat", i), {16'd0, s2}, {16'd0, (c_rr[i] != 0) ? m_rr[i][1] : e2});
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                for (int r = 0; r < 8; r++) m_mem[i][r] = 16'h0000;
                m_start[i] = -1000;
                m_rr[i][0] = 16'h0000;
                m_rr[i][1] = 16'h0000;
            end else begin
                if (m_busy(i)) begin
                    m_mem[i][cyc - m_start[i]] = 16'h0000;
                end else begin
                    if (m_eff(i)) m_mem[i][int'(tgt) % c_n[i]] = tgt_dat & c_mask[i];
                    if (clr) m_start[i] = cyc + 1;
                end
                m_rr[i][0] = nr[i][0];
                m_rr[i][1] = nr[i][1];
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(input int wr_at, output int ca, output int cd);
        ca = 0;
        cd = 0;
        we = 1'b0;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            we = (k == wr_at);
            tgt = 3'd4;
            tgt_dat = 16'hFFFF;
            #2;
            if (ifa.busy) ca++;
            if (ifd.busy) cd++;
            cycle();
        end
        we = 1'b0;
    endtask

    initial begin
        int ca, cd;
        n_chk = 0; n_pass = 0; cyc = 0; checking = 1'b0;
        for (int i = 0; i < 4; i++) m_start[i] = -1000;
        rst_n = 1'b0; we = 1'b0; clr = 1'b0;
        src1 = '0; src2 = '0; tgt = '0; tgt_dat = '0; dbg_addr = '0;
        cycle();
        cycle();
        rst_n = 1'b1;
        checking = 1'b1;
        cycle();

        // zero register and plain write
        we = 1'b1; tgt = 3'd0; tgt_dat = 16'h1234; cycle();
        tgt = 3'd5; cycle();
        we = 1'b0; src1 = 3'd0; src2 = 3'd5; dbg_addr = 3'd5; #2;
        chk("zero reg read", {16'd0, ifa.src1_dat}, 32'h0000);
        chk("r5 read", {16'd0, ifa.src2_dat}, 32'h1234);
        chk("r5 dbg", {16'd0, ifa.dbg_dat}, 32'h1234);
        cycle();

        // bypass vs. no bypass
        we = 1'b1; tgt = 3'd3; tgt_dat = 16'hBEEF; src1 = 3'd3; src2 = 3'd3; #2;
        chk("bypass p1", {16'd0, ifa.src1_dat}, 32'hBEEF);
        chk("bypass p2", {16'd0, ifa.src2_dat}, 32'hBEEF);
        chk("no bypass old", {16'd0, ifb.src1_dat}, 32'h0000);
        cycle();
        we = 1'b0; #2;
        chk("no bypass new", {16'd0, ifb.src1_dat}, 32'hBEEF);
        cycle();

        // registered read latency
        we = 1'b1; tgt = 3'd2; tgt_dat = 16'hA5A5; cycle();
        we = 1'b0; src1 = 3'd2; cycle();
        chk("registered read", {16'd0, ifc.src1_dat}, 32'hA5A5);

        // narrow config without zero register
        we = 1'b1; tgt = 3'd0; tgt_dat = 16'h005A; cycle();
        we = 1'b0; src1 = 3'd0; #2;
        chk("narrow r0 write", {24'd0, ifd.src1_dat}, 32'h5A);
        cycle();

        // full sweep with a dropped mid-sweep write
        for (int r = 1; r < 8; r++) begin
            we = 1'b1; tgt = 3'(r); tgt_dat = 16'(r * 16'h1111); cycle();
        end
        count_busy(3, ca, cd);
        chk("sweep len 8", ca, 8);
        chk("sweep len 4", cd, 4);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r); #2;
            chk($sformatf("post-sweep dbg r%0d", r), {16'd0, ifa.dbg_dat}, 32'h0);
            cycle();
        end

        // reset in the middle of a sweep
        we = 1'b1; tgt = 3'd6; tgt_dat = 16'h6666; cycle();
        tgt = 3'd1; tgt_dat = 16'h1111; cycle();
        we = 1'b0; clr = 1'b1; cycle();
        clr = 1'b0; cycle(); cycle(); cycle();
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; dbg_addr = 3'd6; #2;
        chk("busy after reset", {31'd0, ifa.busy}, 32'd0);
        chk("r6 after reset", {16'd0, ifa.dbg_dat}, 32'h0);
        cycle();
        count_busy(-1, ca, cd);
        chk("sweep after reset", ca, 8);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            src1 = 3'($urandom); src2 = 3'($urandom); tgt = 3'($urandom);
            dbg_addr = 3'($urandom); tgt_dat = 16'($urandom);
            we = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 79) != 0);
            if (k % 8 == 0) src1 = tgt;
            if (k % 5 == 0) src2 = tgt;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
